// File: rtl/glitch_filter_nch_if.sv
// glitch_filter_nch_if: raw inputs, runtime controls and filtered outputs of the glitch filter
//   sig_in : raw asynchronous channel inputs
//   enable : 1 = filtering advances, 0 = freeze
//   mode   : 0 = consecutive-sample, 1 = saturating integrator
//   thr    : stability threshold (0 behaves as 1)
//   sigout : filtered levels
//   rise   : one-cycle 0->1 pulse per channel
//   fall   : one-cycle 1->0 pulse per channel
interface glitch_filter_nch_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic [CHANNELS-1:0] sig_in, sigout, rise, fall;
    logic                enable, mode;
    logic [CNT_W-1:0]    thr;
    modport master (output sig_in, enable, mode, thr, input sigout, rise, fall);
    modport slave  (input sig_in, enable, mode, thr, output sigout, rise, fall);
endinterface

// File: rtl/glitch_filter_nch.sv
// glitch_filter_nch: multi-channel debounce filter with consecutive and integrator modes
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : slave side of glitch_filter_nch_if (sig_in/enable/mode/thr in, sigout/rise/fall out)
module glitch_filter_nch #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 4,
    parameter bit RESET_VAL = 1'b0
) (
    input logic clock,
    input logic reset,
    glitch_filter_nch_if.slave bus
);
    localparam logic [CNT_W:0] ONE = 1;
    logic             mode_q, mchg;
    logic [CNT_W-1:0] t;
    assign t    = (bus.thr == '0) ? ONE[CNT_W-1:0] : bus.thr;
    assign mchg = bus.mode != mode_q;
    // mode_q tracks mode in reset as well, so leaving reset never looks like a mode change
    always_ff @(posedge clock)
        mode_q <= bus.mode;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             s1, s2, q, q_n, r, f;
        logic [CNT_W-1:0] cnt, cnt_n;
        logic [CNT_W:0]   te, c, inc, n;
        always_comb begin
            te    = {1'b0, t};
            // a count left above a freshly lowered threshold is pulled back to it
            c     = ({1'b0, cnt} > te) ? te : {1'b0, cnt};
            inc   = c + ONE;
            n     = s2 ? ((inc > te) ? te : inc) : ((c == '0) ? '0 : c - ONE);
            cnt_n = cnt;
            q_n   = q;
            if (bus.enable) begin
                if (mchg)
                    cnt_n = (bus.mode && q) ? t : '0;
                else if (!bus.mode) begin
                    if (s2 == q)
                        cnt_n = '0;
                    else if ({1'b0, cnt} + ONE >= te) begin
                        q_n   = s2;
                        cnt_n = '0;
                    end else
                        cnt_n = cnt + ONE[CNT_W-1:0];
                end else begin
                    cnt_n = n[CNT_W-1:0];
                    q_n   = (n == te) ? 1'b1 : (n == '0) ? 1'b0 : q;
                end
            end
        end
        always_ff @(posedge clock) begin
            if (!reset) begin
                s1  <= RESET_VAL;
                s2  <= RESET_VAL;
                q   <= RESET_VAL;
                cnt <= '0;
                r   <= 1'b0;
                f   <= 1'b0;
            end else begin
                s1  <= bus.sig_in[i];
                s2  <= s1;
                q   <= q_n;
                cnt <= cnt_n;
                r   <= q_n & ~q;
                f   <= ~q_n & q;
            end
        end
        assign bus.sigout[i] = q;
        assign bus.rise[i]   = r;
        assign bus.fall[i]   = f;
    end
endmodule

// File: tb/tb_glitch_filter_nch.sv
// tb_glitch_filter_nch: scoreboard bench for glitch_filter_nch, expected {sigout,rise,fall} queued per edge
module tb_glitch_filter_nch;
    typedef struct packed {
        logic [3:0] so;
        logic [3:0] r;
        logic [3:0] f;
    } exp_t;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t ex, got;
    glitch_filter_nch_if #(.CHANNELS(4), .CNT_W(4)) bus ();
    glitch_filter_nch #(.CHANNELS(4), .CNT_W(4), .RESET_VAL(1'b0)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clock = ~clock;
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    function automatic exp_t mk(input logic [3:0] so, input logic [3:0] r, input logic [3:0] f);
        mk = '{so: so, r: r, f: f};
    endfunction
    task automatic test_reset;
        bus.mode = 1'b0; bus.thr = 4'd4; bus.enable = 1'b1; bus.sig_in = 4'hF; reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            reset = (e > 2);
            sb.push_back((e == 8) ? mk(4'hF, 4'hF, 4'h0) : mk((e > 8) ? 4'hF : 4'h0, 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL reset e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask
    task automatic test_short_pulse;
        reset = 1'b0; bus.sig_in = 4'h0;
        for (int e = 1; e <= 2; e++) begin
            sb.push_back(mk(4'h0, 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL short_reset e=%0d got=%h exp=%h", e, got, ex); end
        end
        reset = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            bus.sig_in = {3'b0, (e <= 3) || (e >= 9 && e <= 12)};
            sb.push_back(mk((e >= 14 && e <= 17) ? 4'h1 : 4'h0, {3'b0, e == 14}, {3'b0, e == 18}));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL short_pulse e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask
    task automatic test_integrator;
        logic [5:0] seq;
        seq = 6'b111011;
        bus.mode = 1'b1; bus.sig_in = 4'h0;
        for (int e = 1; e <= 16; e++) begin
            bus.sig_in = {1'b0, (e >= 3 && e <= 8) ? seq[e-3] : 1'b0, 2'b0};
            sb.push_back(mk((e >= 10 && e <= 13) ? 4'h4 : 4'h0, (e == 10) ? 4'h4 : 4'h0, (e == 14) ? 4'h4 : 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL integrator e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask
    task automatic test_thr0;
        logic in_v [0:16];
        for (int e = 0; e <= 16; e++)
            in_v[e] = (e >= 1 && e <= 12) ? (((e - 1) / 2) % 2 == 0) : 1'b0;
        bus.mode = 1'b0; bus.thr = 4'd0; bus.sig_in = 4'h0;
        for (int e = 1; e <= 2; e++) begin
            sb.push_back(mk(4'h0, 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL thr0_idle e=%0d got=%h exp=%h", e, got, ex); end
        end
        for (int e = 1; e <= 14; e++) begin
            bus.sig_in = {2'b0, in_v[e], 1'b0};
            sb.push_back(mk({2'b0, (e >= 2) ? in_v[e-2] : 1'b0, 1'b0},
                            {2'b0, (e >= 3) && in_v[e-2] && !in_v[e-3], 1'b0},
                            {2'b0, (e >= 3) && !in_v[e-2] && in_v[e-3], 1'b0}));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL thr0 e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask
    task automatic test_enable;
        bus.thr = 4'd5; bus.sig_in = 4'h8;
        for (int e = 1; e <= 19; e++) begin
            bus.enable = !(e >= 5 && e <= 14);
            sb.push_back(mk((e >= 17) ? 4'h8 : 4'h0, (e == 17) ? 4'h8 : 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL enable e=%0d got=%h exp=%h", e, got, ex); end
        end
        bus.enable = 1'b1;
    endtask
    task automatic test_mid_reset;
        bus.thr = 4'd4; bus.sig_in = 4'h9;
        for (int e = 1; e <= 13; e++) begin
            reset = (e != 6);
            sb.push_back((e <= 5) ? mk(4'h8, 4'h0, 4'h0) : (e <= 11) ? mk(4'h0, 4'h0, 4'h0) :
                         (e == 12) ? mk(4'h9, 4'h9, 4'h0) : mk(4'h9, 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL mid_reset e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask
    task automatic test_mode_toggle;
        bus.sig_in = 4'h5;
        for (int e = 1; e <= 7; e++) begin
            sb.push_back((e < 6) ? mk(4'h9, 4'h0, 4'h0) : (e == 6) ? mk(4'h5, 4'h4, 4'h8) : mk(4'h5, 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL multi_ch e=%0d got=%h exp=%h", e, got, ex); end
        end
        bus.sig_in = 4'hA;
        for (int e = 1; e <= 13; e++) begin
            bus.mode = (e <= 8) ? e[0] : 1'b0;
            sb.push_back((e < 12) ? mk(4'h5, 4'h0, 4'h0) : (e == 12) ? mk(4'hA, 4'hA, 4'h5) : mk(4'hA, 4'h0, 4'h0));
            tick();
            ex = sb.pop_front(); got = {bus.sigout, bus.rise, bus.fall}; checks++;
            if (got !== ex) begin failures++; $display("FAIL mode_toggle e=%0d got=%h exp=%h", e, got, ex); end
        end
    endtask
    initial begin
        test_reset();
        test_short_pulse();
        test_integrator();
        test_thr0();
        test_enable();
        test_mid_reset();
        test_mode_toggle();
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glitch_filter_nch.md
Name: glitch_filter_nch

Overview:
Multi-channel, parametrised glitch/debounce filter; successor to the single-bit 4-sample filter.
- Synchronises CHANNELS asynchronous inputs.
- Qualifies each channel with a runtime stability threshold.
- Two filtering modes: consecutive-sample and saturating integrator.
- Emits filtered levels plus one-cycle edge pulses.
- Sits between raw pad/switch inputs and control logic.

Parameters:
CHANNELS, 4, number of independent input channels
CNT_W, 4, counter/threshold width; thresholds 1..2^CNT_W-1
RESET_VAL, 0, reset level of sigout and synchroniser stages, applied to every channel

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; 0 = reset, 1 = run
sig_in  input  CHANNELS  raw asynchronous inputs
enable  input  1  1 = filtering advances; 0 = freeze
mode  input  1  0 = consecutive, 1 = integrator
thr  input  CNT_W  stability threshold, sampled every cycle; 0 treated as 1
sigout  output  CHANNELS  filtered levels (registered)
rise  output  CHANNELS  one-cycle pulse when sigout[i] goes 0->1 (registered)
fall  output  CHANNELS  one-cycle pulse when sigout[i] goes 1->0 (registered)

Behaviour:
Reset (reset=0 at a rising edge):
- sigout, sync1, sync2 <= {CHANNELS{RESET_VAL}}; all cnt <= 0; rise = fall = 0; mode_q <= mode.
- Takes effect mid-operation too; discards any partial count.

Synchroniser:
- Per channel, 2 flops; sync1 <= sig_in, sync2 <= sync1; s = sync2.
- Always runs, regardless of enable.

Threshold:
- t = (thr == 0) ? 1 : thr.

Mode 0 (consecutive), per channel:
- If s == sigout: cnt <= 0.
- Else if cnt+1 >= t: sigout <= s, cnt <= 0.
- Else: cnt <= cnt+1.

Mode 1 (integrator), per channel:
- n = s ? min(cnt+1, t) : max(cnt-1, 0), computed at CNT_W+1 bits.
- If cnt > t after a thr decrease, n is clamped to t first.
- cnt <= n. If n == t: sigout <= 1. If n == 0: sigout <= 0. Otherwise sigout holds.

Latency:
- Counting the edge at which sig_in is first sampled as edge 1, a clean level change reaches sigout after edge t+2 (mode 0).
- In mode 1 starting from cnt=0 or t, the same t+2.

Mode change:
- mode_q registers mode. When mode != mode_q, for that cycle all counters are reinitialised instead of updating: mode 0 -> cnt=0; mode 1 -> cnt = sigout ? t : 0.
- sigout holds, no edge pulse.

Enable:
- enable=0: cnt and sigout hold; rise = fall = 0; synchroniser keeps running.
- Reset has priority over enable and mode change.

Edge pulses:
- rise[i] = 1 for exactly the cycle in which the newly updated sigout[i] is first visible (registered with sigout).
- Same for fall[i]. Never both high; 0 otherwise.

Widths:
- Counters are CNT_W bits per channel and never wrap: mode 0 resets at t, mode 1 saturates.

Channels:
- Fully independent; simultaneous events on several channels are each handled in the same cycle.

Test Plan:
1. CHANNELS=4, RESET_VAL=0, thr=4, mode=0; hold reset=0 for 2 edges with sig_in=4'hF -> sigout=0, rise=fall=0. Release reset with sig_in=4'hF held -> sigout=4'hF after edge 6, rise=4'hF for that single cycle only, then 0.
2. thr=4, mode=0, sigout=0; sig_in[0] high for 3 cycles then low -> sigout[0] stays 0, rise[0] never asserts. sig_in[0] high for 4 cycles -> sigout[0]=1 after edge 6.
3. mode=1, thr=4, cnt=0; sig_in[2] samples 1,1,0,1,1,1 -> cnt 1,2,1,2,3,4; sigout[2]=1 after edge 8 (6 samples + 2 sync). Then 4 samples of 0 -> sigout[2]=0, fall[2] pulse.
4. thr=0, mode=0; toggle sig_in[1] every 2 cycles -> sigout[1] follows with 3-edge delay; rise/fall pulses alternate.
5. mode=0, thr=5, sig_in[3]=1 held; drop enable for 10 cycles after 2 counted edges, then raise it -> sigout[3] rises exactly 3 edges after enable returns. No pulses while enable=0.
6. Mid-count (cnt=3, thr=4) assert reset=0 one edge -> sigout=0, cnt=0. Also toggle mode while sigout=4'h5 -> sigout holds 4'h5, no rise/fall pulse.
